// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 row-scanned matrix keypad reader.
// Debounces one key at a time and strobes its code once per press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_TICKS > 1) ?
                      $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      col_m;
  logic [3:0]      col_s;
  logic [DW-1:0]   div;
  logic            tick;
  logic [1:0]      row_idx;
  logic [1:0]      row_nx;
  logic [1:0]      key_row;
  logic [1:0]      key_row_nx;
  logic [1:0]      key_col;
  logic [1:0]      key_col_nx;
  logic [1:0]      low_col;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic            valid_nx;
  logic            key_up;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_MAX) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tick   = (div == DIV_MAX);
  assign key_up = col_s[key_col];

  // Several columns may be low together; the lowest index wins.
  always_comb begin
    low_col = 2'd0;
    priority case (1'b1)
      !col_s[0]: low_col = 2'd0;
      !col_s[1]: low_col = 2'd1;
      !col_s[2]: low_col = 2'd2;
      !col_s[3]: low_col = 2'd3;
      default:   low_col = 2'd0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    row_nx     = row_idx;
    cnt_nx     = cnt;
    key_row_nx = key_row;
    key_col_nx = key_col;
    valid_nx   = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (col_s == 4'hF) begin
            row_nx = row_idx + 2'd1;
          end else begin
            key_row_nx = row_idx;
            key_col_nx = low_col;
            cnt_nx     = '0;
            state_nx   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (key_up) begin
            row_nx   = row_idx + 2'd1;
            state_nx = SCAN;
          end else if (cnt == CNT_MAX) begin
            valid_nx = 1'b1;
            state_nx = HELD;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        HELD: begin
          if (key_up) begin
            cnt_nx   = '0;
            state_nx = RELEASE;
          end
        end
        RELEASE: begin
          if (!key_up) begin
            cnt_nx   = '0;
            state_nx = HELD;
          end else if (cnt == CNT_MAX) begin
            row_nx   = row_idx + 2'd1;
            state_nx = SCAN;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      row_out   <= 4'b1110;
      cnt       <= '0;
      key_row   <= 2'd0;
      key_col   <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      row_idx   <= row_nx;
      row_out   <= ~(4'b0001 << row_nx);
      cnt       <= cnt_nx;
      key_row   <= key_row_nx;
      key_col   <= key_col_nx;
      key_valid <= valid_nx;
      if (valid_nx) begin
        key_code <= {key_row, key_col};
      end
      key_held  <= (state_nx == HELD) ||
                   (state_nx == RELEASE);
    end
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Row-scanned 4x4 matrix keypad reader: drives one row low at a time, samples the column lines, debounces a detected press and reports a 4-bit key code with a one-cycle valid strobe. It handles the input side of the board's multiplexed I/O, where the digit multiplexer handles the output side, and runs on the same 25 MHz clock. It feeds key codes to the control logic that loads the displayed digits.

## Interface
- SCAN_DIV, default 25000: clock cycles per row period (1 ms at 25 MHz); must be >= 4.
- DEBOUNCE_TICKS, default 20: consecutive row-period ticks a level must persist to be accepted; must be >= 1.
- clk  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high.
- col_in  in  4  column lines, active low, externally pulled up; asynchronous to clk.
- row_out  out  4  row drives, active low, exactly one bit low at all times.
- key_code  out  4  last accepted key, {row[1:0], col[1:0]}.
- key_valid  out  1  one-cycle strobe when key_code updates.
- key_held  out  1  high while the accepted key remains pressed.

## Operation
- col_in passes through a 2-flop synchronizer (col_s). All decisions use col_s only.
- Divider div counts 0..SCAN_DIV-1 and wraps. tick = (div == SCAN_DIV-1). div runs freely in every state.
- row_idx is 2 bits. row_out = ~(4'b0001 << row_idx).
- cnt is a debounce counter wide enough for DEBOUNCE_TICKS-1.
- FSM states are SCAN, DEBOUNCE, HELD and RELEASE. All transitions occur only on tick.
- SCAN:
  - If col_s == 4'hF, row_idx increments and wraps 3->0.
  - Otherwise, capture row_idx and the lowest-index low column into key_row/key_col, set cnt=0 and go to DEBOUNCE. row_idx is frozen.
- DEBOUNCE:
  - If col_s[key_col] is high, it was a bounce: row_idx increments and the FSM goes to SCAN.
  - Else if cnt == DEBOUNCE_TICKS-1, key_code <= {key_row, key_col}, key_valid pulses and the FSM goes to HELD.
  - Else cnt++.
- HELD:
  - key_held = 1.
  - If col_s[key_col] is high, set cnt=0 and go to RELEASE.
- RELEASE:
  - key_held stays 1.
  - If col_s[key_col] is low, set cnt=0 and go to HELD.
  - Else if cnt == DEBOUNCE_TICKS-1, row_idx increments, key_held drops and the FSM goes to SCAN.
  - Else cnt++.
- Rollover:
  - Only the captured key is tracked from DEBOUNCE through RELEASE. Other columns going low are ignored.
  - A second key in another row is not seen until SCAN resumes.
  - A second key in the same row that is still pressed after release is detected on the next SCAN pass of that row.
- Simultaneous columns low in SCAN: the lowest index wins (col 0 has priority over col 3).

## Timing
- Reset values: state SCAN, div 0, row_idx 0, row_out 4'b1110, cnt 0, synchronizer flops 4'hF, key_code 4'h0, key_valid 0, key_held 0.
- All outputs are registered.
- key_valid is high exactly one cycle: the cycle after the qualifying tick. key_code changes in that same cycle and holds until the next key_valid.
- Row settle: a row is driven for SCAN_DIV-1 cycles before its sample. The synchronizer adds 2 cycles, which is covered by SCAN_DIV >= 4.
- Press latency, measured from the DEBOUNCE-entry tick to key_valid: DEBOUNCE_TICKS*SCAN_DIV + 1 cycles.
- Release latency, measured from the HELD->RELEASE tick to key_held low: DEBOUNCE_TICKS*SCAN_DIV + 1 cycles.
- Worst-case detect delay, from a stable press to the SCAN capture: 4*SCAN_DIV + 2 cycles.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously. No key_valid is emitted during or directly after reset.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_TICKS=3.
- Reset and idle scan, no keys pressed:
  - After reset deassert, row_out = 1110.
  - row_out then steps 1101, 1011, 0111, 1110, each step every 4 cycles.
  - key_valid stays 0 throughout.
- Clean press and release of row 2, col 1 (col_in[1] low only while row_out[2]=0, held 40 cycles):
  - Exactly one key_valid pulse, with key_code = 4'b1001.
  - key_held rises with key_valid.
  - key_held falls 13 cycles after the release is seen at a tick; scanning then resumes at row 3.
- Bounce: row 0, col 3 pressed for 6 cycles, then released:
  - No key_valid.
  - FSM returns to SCAN and scanning resumes at row 1.
- Release glitch: in HELD, col high for 1 tick, then low again:
  - key_held stays 1 and no second key_valid occurs.
  - A later clean release drops key_held.
- Column priority: row 1 with cols 0 and 2 low together -> key_code = 4'b0100.
- Reset mid-DEBOUNCE (assert reset during DEBOUNCE):
  - row_out = 1110 and key_valid = 0 immediately.
  - After deassert with the key still held, a normal detection yields exactly one key_valid pulse.
